// File: rtl/fpmul_pkg.sv
// fpmul_pkg: shared definitions for the floating-point multiplier scheduler.
//   - Word geometry (WIDTH, WEXP, WSIG) and control field width (WCONTROL).
//   - Round mode encodings carried in control bits [1:0].
//   - Scheduler FSM state encoding.
//   - clog2: ceiling log2 for sizing requester IDs.
//   - sat_inc16: saturating 16-bit increment used by the optional counters.
package fpmul_pkg;

    localparam int WIDTH    = 32;
    localparam int WEXP     = 8;
    localparam int WSIG     = 23;
    localparam int WCONTROL = 5;

    typedef enum logic [1:0] {
        RN = 2'b00,
        RZ = 2'b01,
        RP = 2'b10,
        RM = 2'b11
    } round_mode_e;

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_DRAIN = 2'b01,
        ST_DONE  = 2'b10
    } sched_state_e;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result = result + 1;
        end
        return result;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/fpmul_sched_rr_arbiter.sv
// rr_arbiter: NREQ-wide round-robin priority select.
//   req     - request vector
//   pointer - highest-priority requester this cycle (0..NREQ-1)
//   grant   - one-hot grant (all zero when no request)
//   index   - binary index of the granted requester
//   any     - at least one request present
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  pointer,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  index,
    output logic            any
);
    import fpmul_pkg::*;

    logic [NREQ-1:0] rot_s;
    int              first_s;
    int              sum_s;

    // Rotate requests so the pointer sits at bit 0, find the lowest set bit,
    // then map that offset back to an absolute requester index.
    always_comb begin
        rot_s   = NREQ'({req, req} >> pointer);
        first_s = 0;
        // Descending scan leaves the lowest set offset in first_s.
        for (int k = NREQ - 1; k >= 0; k--) begin
            first_s = rot_s[k] ? k : first_s;
        end
        sum_s = int'(pointer) + first_s;
        sum_s = (sum_s >= NREQ) ? (sum_s - NREQ) : sum_s;
        any   = |req;
        index = IDW'(sum_s);
        grant = any ? (NREQ'(1) << index) : {NREQ{1'b0}};
    end

endmodule

// File: rtl/fpmul_sched.sv
// fpmul_sched: round-robin scheduler sharing one fixed-latency pipelined
// floating-point multiplier between NREQ requesters.
//   clk, rst_n            - clock, asynchronous active-low reset
//   req_valid/req_ready   - per-requester handshake; req_a/req_b/req_control packed
//   mul_a/mul_b/mul_control, mul_en, mul_result - multiplier interface
//   res_valid/res_ready, res_data, res_id - tagged result stream, in issue order
//   flush_req/flush_done  - drain handshake; busy - any op in flight
// Optional build macro FPMUL_SCHED_PERF_EN adds perf_clr, perf_grants (per
// requester 16-bit saturating grant counts) and perf_stalls (16-bit saturating
// stall-cycle count).
module fpmul_sched #(
    parameter  int NREQ     = 4,
    parameter  int WIDTH    = fpmul_pkg::WIDTH,
    parameter  int WCONTROL = fpmul_pkg::WCONTROL,
    parameter  int LAT      = 3,
    localparam int IDW      = fpmul_pkg::clog2(NREQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*WIDTH-1:0]    req_a,
    input  logic [NREQ*WIDTH-1:0]    req_b,
    input  logic [NREQ*WCONTROL-1:0] req_control,
    output logic [WIDTH-1:0]         mul_a,
    output logic [WIDTH-1:0]         mul_b,
    output logic [WCONTROL-1:0]      mul_control,
    output logic                     mul_en,
    input  logic [WIDTH-1:0]         mul_result,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [WIDTH-1:0]         res_data,
    output logic [IDW-1:0]           res_id,
    input  logic                     flush_req,
    output logic                     flush_done,
`ifdef FPMUL_SCHED_PERF_EN
    input  logic                     perf_clr,
    output logic [NREQ*16-1:0]       perf_grants,
    output logic [15:0]              perf_stalls,
`endif
    output logic                     busy
);
    import fpmul_pkg::*;

    sched_state_e    state_r;
    sched_state_e    state_nxt_s;
    logic            run_s;
    logic [IDW-1:0]  ptr_r;
    logic [LAT-1:0]  vld_r;
    logic [IDW-1:0]  tag_r [LAT];
    logic            hold_s;
    logic            issue_ok_s;
    logic            accept_s;
    logic [NREQ-1:0] grant_s;
    logic [IDW-1:0]  gidx_s;
    logic            gany_s;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req     (req_valid),
        .pointer (ptr_r),
        .grant   (grant_s),
        .index   (gidx_s),
        .any     (gany_s)
    );

    // A result waiting on the consumer freezes the whole pipeline.
    assign hold_s     = vld_r[LAT-1] & ~res_ready;
    assign mul_en     = ~hold_s;
    // rst_n term keeps req_ready low while reset is held, so no requester
    // sees a handshake that the (cleared) pipeline will not honour.
    assign issue_ok_s = run_s & ~hold_s & rst_n;
    assign accept_s   = issue_ok_s & gany_s;
    assign req_ready  = grant_s & {NREQ{issue_ok_s}};

    // Operand mux: always follows the arbiter choice; only meaningful on accept.
    always_comb begin
        mul_a       = req_a[int'(gidx_s) * WIDTH +: WIDTH];
        mul_b       = req_b[int'(gidx_s) * WIDTH +: WIDTH];
        mul_control = req_control[int'(gidx_s) * WCONTROL +: WCONTROL];
    end

    // Round-robin pointer: moves just past the requester that was accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r <= '0;
        end else if (accept_s) begin
            ptr_r <= (gidx_s == IDW'(NREQ - 1)) ? '0 : gidx_s + IDW'(1);
        end
    end

    // Valid/tag shadow pipeline, advancing in lockstep with the multiplier.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_r <= '0;
            for (int i = 0; i < LAT; i++) begin
                tag_r[i] <= '0;
            end
        end else if (!hold_s) begin
            vld_r[0] <= accept_s;
            tag_r[0] <= gidx_s;
            for (int i = 1; i < LAT; i++) begin
                vld_r[i] <= vld_r[i-1];
                tag_r[i] <= tag_r[i-1];
            end
        end
    end

    assign res_valid = vld_r[LAT-1];
    assign res_id    = tag_r[LAT-1];
    assign res_data  = mul_result;
    assign busy      = |vld_r;

    // Flush FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Flush FSM next-state logic. From RUN an already-empty pipeline with no
    // issue this cycle skips DRAIN so flush_done follows one cycle later.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_RUN: begin
                if (flush_req) begin
                    state_nxt_s = (!busy && !accept_s) ? ST_DONE : ST_DRAIN;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (!flush_req) begin
                    state_nxt_s = ST_RUN;
                end else if (!busy) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            ST_DONE: begin
                state_nxt_s = flush_req ? ST_DONE : ST_RUN;
            end
            default: begin
                state_nxt_s = ST_RUN;
            end
        endcase
    end

    // Flush FSM outputs, decoded straight from the state register.
    always_comb begin
        run_s      = 1'b0;
        flush_done = 1'b0;
        case (state_r)
            ST_RUN:   run_s      = 1'b1;
            ST_DONE:  flush_done = 1'b1;
            default: begin
                run_s      = 1'b0;
                flush_done = 1'b0;
            end
        endcase
    end

`ifdef FPMUL_SCHED_PERF_EN
    logic [NREQ-1:0][15:0] grant_cnt_r;
    logic [15:0]           stall_cnt_r;

    // Saturating usage counters; perf_clr takes priority over counting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_cnt_r <= '0;
            stall_cnt_r <= '0;
        end else if (perf_clr) begin
            grant_cnt_r <= '0;
            stall_cnt_r <= '0;
        end else begin
            for (int k = 0; k < NREQ; k++) begin
                if (accept_s && grant_s[k]) begin
                    grant_cnt_r[k] <= sat_inc16(grant_cnt_r[k]);
                end
            end
            if (hold_s) begin
                stall_cnt_r <= sat_inc16(stall_cnt_r);
            end
        end
    end

    assign perf_grants = grant_cnt_r;
    assign perf_stalls = stall_cnt_r;
`else
    // Counters are not built in this configuration.
`endif

endmodule

// File: doc/fpmul_sched.md
Name: fpmul_sched

Overview:
- Round-robin scheduler that shares one fixed-latency pipelined floating-point multiplier between NREQ requesters.
- Accepts operand pairs over valid/ready handshakes and issues at most one operation per cycle into the multiplier.
- Tracks each requester ID through the pipeline and returns every result tagged with its ID, with output backpressure.
- Provides a drain/flush sequence so software can quiesce the multiplier before changing round mode or resetting datapath state.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 32, floating-point word width.
- WCONTROL, 5, control field width; bits [1:0] carry round mode.
- LAT, 3, multiplier pipeline latency in cycles (>=1).

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  per-requester operation valid.
- req_ready  out  NREQ  per-requester accept.
- req_a  in  NREQ*WIDTH  operand A, packed; requester i occupies [i*WIDTH +: WIDTH].
- req_b  in  NREQ*WIDTH  operand B, packed.
- req_control  in  NREQ*WCONTROL  control field, packed.
- mul_a, mul_b  out  WIDTH  operands to the multiplier.
- mul_control  out  WCONTROL  control field to the multiplier.
- mul_en  out  1  multiplier pipeline advance enable.
- mul_result  in  WIDTH  multiplier output, valid LAT advancing cycles after issue.
- res_valid  out  1  result valid.
- res_ready  in  1  downstream accept.
- res_data  out  WIDTH  product (equals mul_result).
- res_id  out  clog2(NREQ)  requester ID of the result.
- flush_req  in  1  level request to drain.
- flush_done  out  1  pipeline empty and issue blocked.
- busy  out  1  any operation in flight.

Behaviour:
- Reset (async, rst_n=0):
  - valid/tag shift register cleared.
  - Round-robin pointer = 0; state = RUN.
  - res_valid = 0, flush_done = 0, busy = 0.
  - req_ready = 0; mul_en = 1.
- Stall: hold = res_valid & ~res_ready. mul_en = ~hold. When hold=1, no issue occurs and the pipeline and tags freeze.
- Arbitration:
  - Grant goes to the first asserted req_valid at or after the pointer, wrapping modulo NREQ.
  - req_ready[g] = 1 only for granted g, only when state==RUN and ~hold. req_ready may depend combinationally on req_valid.
  - On accept, mul_a/b/control are driven from requester g in the same cycle, and stage 0 is loaded with valid=1, tag=g.
  - After an accept, pointer <= g+1 mod NREQ. With no accept, the pointer holds.
- Pipeline: a shift register of LAT entries {valid, tag} advances when mul_en=1, and stage 0 is loaded with valid=0 when nothing is issued.
  - res_valid = last stage valid; res_id = last stage tag; res_data = mul_result.
  - Latency is exactly LAT cycles from accept to res_valid with no stalls.
  - Throughput is 1 op/cycle.
- Ordering: results are returned strictly in issue order.
- busy = OR of all stage valids.
- FSM:
  - RUN --flush_req--> DRAIN. Issue is blocked in DRAIN.
  - DRAIN --~busy--> DONE, asserting flush_done=1 (registered; asserts the cycle after busy falls).
  - DONE --~flush_req--> RUN.
  - flush_req deasserted while in DRAIN: go to RUN, with no flush_done pulse.
  - flush_req asserted with the pipeline already empty: DONE on the next cycle.
- Boundaries:
  - All requesters valid: strict rotation 0,1,..,NREQ-1,0.
  - Single requester: back-to-back issue every cycle.
  - Reset mid-operation drops in-flight ops silently; requesters must re-issue.
- Non-power-of-2 NREQ: the pointer wraps at NREQ-1, and res_id never exceeds NREQ-1.

Optional Feature:
- Macro FPMUL_SCHED_PERF_EN.
- When defined:
  - Adds a per-requester 16-bit grant counter, saturating at 0xFFFF.
  - Adds a 16-bit stall counter, counting cycles with hold=1, saturating.
  - Counters are exposed on perf_grants (NREQ*16) and perf_stalls (16).
  - Both counters clear on reset and on input perf_clr (synchronous, 1 cycle).
- When undefined: those ports and registers are absent, and behaviour is otherwise identical.

Decomposition:
- Shared package/include fpmul_pkg:
  - Constants: WIDTH, WEXP, WSIG, WCONTROL.
  - Round mode encodings: RN=00, RZ=01, RP=10, RM=11.
  - Scheduler FSM state encoding: RUN, DRAIN, DONE.
  - Helper function clog2.
- One sub-module, rr_arbiter: NREQ-wide round-robin priority select, with inputs req/pointer and outputs onehot grant/index/any.

Test Plan:
- Single request: requester 2 issues a=0x3FC00000 (1.5), b=0x40000000 (2.0), with res_ready=1. Expect res_valid at exactly cycle+3, res_data=0x40400000, res_id=2.
- All four valid continuously for 8 cycles, res_ready=1: accepts occur in order 0,1,2,3,0,1,2,3. Results have res_id in the same order, one per cycle.
- Backpressure: hold res_ready=0 for 5 cycles with results pending. Expect mul_en=0, all req_ready=0, and res_data/res_id stable. On release, no result is lost or duplicated.
- Flush: flush_req=1 with 3 ops in flight. Expect no new accepts; flush_done=1 one cycle after the last result handshake. Dropping flush_req returns to RUN.
- Reset mid-stream: rst_n=0 with 2 ops in flight. Expect immediate res_valid=0 and busy=0; after reset, the first grant goes to requester 0.
- With FPMUL_SCHED_PERF_EN: 10 grants to requester 1 and 4 stall cycles. Expect perf_grants[1]=10 and perf_stalls=4. perf_clr zeroes both.
